// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the framed shift register.
package shift_reg_pkg;

    // Operation selected by the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_ROL  = 2'b11
    } mode_e;

    // Width of the readout window index. It is never narrower than one bit,
    // so that a single-window configuration still has a legal port.
    function automatic int sel_width(input int width, input int out_w);
        int n;
        n = width / out_w;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_reg_framed_frame_counter.sv
// Counts shift operations modulo FRAME_LEN and produces a registered wrap pulse.
// last_step tells the parent, during the cycle itself, that the current edge
// completes a frame, so the parent can capture the new data on that same edge.
module frame_counter #(
    parameter int FRAME_LEN = 32
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    input  logic step,
    input  logic clear,
    output logic last_step,
    output logic wrap
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;

    // Next count and wrap. clear beats step, and wrap falls on any cycle that does not wrap.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        last_step  = step && !clear && (count_reg == LAST);
        if (clear) begin
            count_next = '0;
        end else if (step) begin
            if (count_reg == LAST) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign wrap = wrap_reg;

endmodule

// File: rtl/shift_reg_framed.sv
// Parametrised shift register with shift, rotate and parallel load. It captures
// the register into a snapshot after every FRAME_LEN shifts and reads that
// snapshot out through a narrow window selected by byte_sel.
module shift_reg_framed
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OUT_W     = 8,
    parameter int FRAME_LEN = WIDTH,
    localparam int SEL_W    = sel_width(WIDTH, OUT_W)
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             d,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SEL_W-1:0] byte_sel,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             frame_done,
    output logic [WIDTH-1:0] snap,
    output logic [OUT_W-1:0] out_byte
);

    localparam int NUM_WIN = WIDTH / OUT_W;

    mode_e            mode_v;
    logic             shift_op;
    logic             last_step;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             serial_out_reg;
    logic             serial_out_next;
    logic [WIDTH-1:0] snap_reg;
    logic [OUT_W-1:0] window [NUM_WIN];

    assign mode_v   = mode_e'(mode);
    assign shift_op = en && (mode_v != MODE_HOLD);

    // Data path next state. load takes precedence over any shift, and hold
    // keeps both q and serial_out.
    always_comb begin
        q_next          = q_reg;
        serial_out_next = serial_out_reg;
        if (load) begin
            q_next = load_data;
        end else if (shift_op) begin
            case (mode_v)
                MODE_SHL: begin
                    q_next          = {q_reg[WIDTH-2:0], d};
                    serial_out_next = q_reg[WIDTH-1];
                end
                MODE_SHR: begin
                    q_next          = {d, q_reg[WIDTH-1:1]};
                    serial_out_next = q_reg[0];
                end
                MODE_ROL: begin
                    q_next          = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    serial_out_next = q_reg[WIDTH-1];
                end
                default: begin
                    q_next          = q_reg;
                    serial_out_next = serial_out_reg;
                end
            endcase
        end
    end

    // Shift register, serial output and frame snapshot. The snapshot takes the
    // value that q is about to hold, not the value it holds now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg          <= '0;
            serial_out_reg <= 1'b0;
            snap_reg       <= '0;
        end else begin
            q_reg          <= q_next;
            serial_out_reg <= serial_out_next;
            if (last_step) begin
                snap_reg <= q_next;
            end
        end
    end

    frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk       (clk),
        .rst       (rst),
        .step      (shift_op),
        .clear     (load),
        .last_step (last_step),
        .wrap      (frame_done)
    );

    // Slice the snapshot into readout windows.
    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
        assign window[gi] = snap_reg[gi*OUT_W +: OUT_W];
    end

    // Window select. An index past the last window reads as zero.
    always_comb begin
        out_byte = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (int'(byte_sel) == i) begin
                out_byte = window[i];
            end
        end
    end

    assign q          = q_reg;
    assign serial_out = serial_out_reg;
    assign snap       = snap_reg;

endmodule

// File: tb/tb_shift_reg_framed.sv
// Directed self-checking bench for shift_reg_framed (32/8/32). A second
// instance with FRAME_LEN=1 covers back-to-back frames.
module tb_shift_reg_framed;
    import shift_reg_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic        d;
    logic        load;
    logic [31:0] load_data;
    logic [1:0]  byte_sel;

    logic [31:0] q,  snap,  q1,  snap1;
    logic        serial_out, frame_done, so1, fd1;
    logic [7:0]  out_byte, ob1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q;
    logic        exp_so;

    shift_reg_framed #(.WIDTH(32), .OUT_W(8), .FRAME_LEN(32)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .load(load),
        .load_data(load_data), .byte_sel(byte_sel), .q(q),
        .serial_out(serial_out), .frame_done(frame_done), .snap(snap),
        .out_byte(out_byte)
    );

    shift_reg_framed #(.WIDTH(32), .OUT_W(8), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .load(load),
        .load_data(load_data), .byte_sel(byte_sel), .q(q1),
        .serial_out(so1), .frame_done(fd1), .snap(snap1),
        .out_byte(ob1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; mode = 2'b00; d = 1'b0; load = 1'b0;
        load_data = '0; byte_sel = 2'd0;
        #1 rst = 1'b0;
        #1;
        checks++; if (q !== 32'h0) begin failures++; $display("FAIL reset_q actual=%h required=%h", q, 32'h0); end
        checks++; if (snap !== 32'h0) begin failures++; $display("FAIL reset_snap actual=%h required=%h", snap, 32'h0); end
        checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL reset_serial_out actual=%b required=0", serial_out); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done actual=%b required=0", frame_done); end
        checks++; if (out_byte !== 8'h0) begin failures++; $display("FAIL reset_out_byte actual=%h required=00", out_byte); end
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); mode = 2'($urandom); d = 1'($urandom);
            load = 1'($urandom); load_data = $urandom; byte_sel = 2'($urandom);
            tick();
            checks++; if (q !== 32'h0) begin failures++; $display("FAIL reset_hold_q actual=%h required=%h", q, 32'h0); end
            checks++; if (snap !== 32'h0 || out_byte !== 8'h0) begin failures++; $display("FAIL reset_hold_snap actual=%h/%h required=0/0", snap, out_byte); end
            checks++; if (serial_out !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL reset_hold_flags actual=%b%b required=00", serial_out, frame_done); end
        end
        en = 1'b0; load = 1'b0; mode = 2'b00; d = 1'b0; byte_sel = 2'd0;
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_serial_capture;
        logic [31:0] word;
        word = 32'hA5A51234;
        en = 1'b1; mode = 2'b01;
        for (int i = 31; i >= 0; i--) begin
            d = word[i];
            tick();
            if (i != 0) begin
                checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL capture_early_done bit=%0d actual=%b required=0", i, frame_done); end
            end
        end
        en = 1'b0;
        checks++; if (q !== 32'hA5A51234) begin failures++; $display("FAIL capture_q actual=%h required=a5a51234", q); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL capture_done actual=%b required=1", frame_done); end
        checks++; if (snap !== 32'hA5A51234) begin failures++; $display("FAIL capture_snap actual=%h required=a5a51234", snap); end
        byte_sel = 2'd0; #1;
        checks++; if (out_byte !== 8'h34) begin failures++; $display("FAIL capture_byte0 actual=%h required=34", out_byte); end
        byte_sel = 2'd1; #1;
        checks++; if (out_byte !== 8'h12) begin failures++; $display("FAIL capture_byte1 actual=%h required=12", out_byte); end
        byte_sel = 2'd3; #1;
        checks++; if (out_byte !== 8'hA5) begin failures++; $display("FAIL capture_byte3 actual=%h required=a5", out_byte); end
        tick();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL capture_done_pulse actual=%b required=0", frame_done); end
        checks++; if (q !== 32'hA5A51234) begin failures++; $display("FAIL capture_hold_q actual=%h required=a5a51234", q); end
        $display("test_serial_capture done");
    endtask

    task automatic test_right_shift;
        load = 1'b1; load_data = 32'h80000001; en = 1'b1; mode = 2'b10; d = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (q !== 32'h80000001) begin failures++; $display("FAIL right_load_q actual=%h required=80000001", q); end
        d = 1'b0;
        tick();
        en = 1'b0;
        checks++; if (q !== 32'h40000000) begin failures++; $display("FAIL right_q actual=%h required=40000000", q); end
        checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL right_serial_out actual=%b required=1", serial_out); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL right_done actual=%b required=0", frame_done); end
        $display("test_right_shift done");
    endtask

    task automatic test_rotate;
        load = 1'b1; load_data = 32'h80000001; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b11; d = 1'b0;
        tick();
        checks++; if (q !== 32'h00000003) begin failures++; $display("FAIL rotate_q1 actual=%h required=00000003", q); end
        checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL rotate_so1 actual=%b required=1", serial_out); end
        for (int i = 0; i < 31; i++) begin
            d = 1'($urandom);
            tick();
            if (i != 30) begin
                checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rotate_early_done step=%0d actual=%b required=0", i, frame_done); end
            end
        end
        en = 1'b0;
        checks++; if (q !== 32'h80000001) begin failures++; $display("FAIL rotate_q32 actual=%h required=80000001", q); end
        checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL rotate_so32 actual=%b required=1", serial_out); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL rotate_done actual=%b required=1", frame_done); end
        checks++; if (snap !== 32'h80000001) begin failures++; $display("FAIL rotate_snap actual=%h required=80000001", snap); end
        byte_sel = 2'd3; #1;
        checks++; if (out_byte !== 8'h80) begin failures++; $display("FAIL rotate_byte3 actual=%h required=80", out_byte); end
        $display("test_rotate done");
    endtask

    task automatic test_load_collision;
        exp_q = 32'h80000001;
        exp_so = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (i == 10 || i == 20) begin
                en = 1'b0; mode = 2'b01; d = 1'b1;
                tick();
                en = 1'b1; mode = 2'b00;
                tick();
                checks++; if (q !== exp_q || frame_done !== 1'b0) begin failures++; $display("FAIL hold_q step=%0d actual=%h/%b required=%h/0", i, q, frame_done, exp_q); end
                checks++; if (serial_out !== exp_so) begin failures++; $display("FAIL hold_serial_out step=%0d actual=%b required=%b", i, serial_out, exp_so); end
            end
            en = 1'b1; mode = 2'b01; d = 1'b1;
            exp_so = exp_q[31];
            exp_q = {exp_q[30:0], 1'b1};
            tick();
            checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL collision_early_done step=%0d actual=%b required=0", i, frame_done); end
        end
        load = 1'b1; load_data = 32'hDEADBEEF; en = 1'b1; mode = 2'b01; d = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (q !== 32'hDEADBEEF) begin failures++; $display("FAIL collision_q actual=%h required=deadbeef", q); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL collision_done actual=%b required=0", frame_done); end
        checks++; if (snap !== 32'h80000001) begin failures++; $display("FAIL collision_snap actual=%h required=80000001", snap); end
        checks++; if (serial_out !== exp_so) begin failures++; $display("FAIL collision_serial_out actual=%b required=%b", serial_out, exp_so); end
        exp_q = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                mode = 2'b01; d = exp_q[31];
            end else begin
                mode = 2'b11; d = ~exp_q[31];
            end
            exp_q = {exp_q[30:0], exp_q[31]};
            tick();
            if (i != 31) begin
                checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL refill_early_done step=%0d actual=%b required=0", i, frame_done); end
            end
        end
        en = 1'b0;
        checks++; if (q !== 32'hDEADBEEF) begin failures++; $display("FAIL refill_q actual=%h required=deadbeef", q); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL refill_done actual=%b required=1", frame_done); end
        checks++; if (snap !== 32'hDEADBEEF) begin failures++; $display("FAIL refill_snap actual=%h required=deadbeef", snap); end
        byte_sel = 2'd2; #1;
        checks++; if (out_byte !== 8'hAD) begin failures++; $display("FAIL refill_byte2 actual=%h required=ad", out_byte); end
        $display("test_load_collision done");
    endtask

    task automatic test_mid_reset;
        en = 1'b1; mode = 2'b01; d = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        rst = 1'b0;
        #1;
        checks++; if (q !== 32'h0 || snap !== 32'h0) begin failures++; $display("FAIL midreset_q_snap actual=%h/%h required=0/0", q, snap); end
        checks++; if (serial_out !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL midreset_flags actual=%b%b required=00", serial_out, frame_done); end
        checks++; if (out_byte !== 8'h0) begin failures++; $display("FAIL midreset_out_byte actual=%h required=00", out_byte); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i != 31) begin
                checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL midreset_early_done step=%0d actual=%b required=0", i, frame_done); end
            end
        end
        en = 1'b0;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL midreset_done actual=%b required=1", frame_done); end
        checks++; if (q !== 32'hFFFFFFFF || snap !== 32'hFFFFFFFF) begin failures++; $display("FAIL midreset_q_snap32 actual=%h/%h required=ffffffff", q, snap); end
        $display("test_mid_reset done");
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_b2b [4];
        exp_b2b[0] = 32'h2468ACF1;
        exp_b2b[1] = 32'h48D159E3;
        exp_b2b[2] = 32'h91A2B3C7;
        exp_b2b[3] = 32'h2345678F;
        load = 1'b1; load_data = 32'h12345678;
        tick();
        load = 1'b0;
        checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL b2b_load_done actual=%b required=0", fd1); end
        en = 1'b1; mode = 2'b01; d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (fd1 !== 1'b1) begin failures++; $display("FAIL b2b_done step=%0d actual=%b required=1", i, fd1); end
            checks++; if (snap1 !== exp_b2b[i]) begin failures++; $display("FAIL b2b_snap step=%0d actual=%h required=%h", i, snap1, exp_b2b[i]); end
        end
        en = 1'b0;
        tick();
        checks++; if (fd1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_done actual=%b required=0", fd1); end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_serial_capture();
        test_right_shift();
        test_rotate();
        test_load_collision();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
